// File: rtl/timer_pulse_capture.sv
// timer_pulse_capture: input-capture companion to the compare-match timer.
// Measures the period (rising to rising) and high time (rising to falling)
// of cap_in in prescaled ticks, using the timer's clock-select scheme.
module timer_pulse_capture #(
    parameter int BIT_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [1:0]           cks,
    input  logic                 ext_clk,
    input  logic                 cap_in,
    input  logic                 ovf_clr,
    output logic [BIT_WIDTH-1:0] period,
    output logic [BIT_WIDTH-1:0] high_time,
    output logic                 cap_valid,
    output logic                 ovf,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    logic [SYNC_STAGES-1:0] cap_sync_q, ext_sync_q;
    logic                   cap_prev_q, ext_prev_q;
    logic [5:0]             pre_q;
    logic [1:0]             state_q, state_d;
    logic [BIT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0]   hi_shadow_q, hi_shadow_d;
    logic [BIT_WIDTH-1:0]   period_q, period_d;
    logic [BIT_WIDTH-1:0]   high_time_q, high_time_d;
    logic                   cap_valid_q, cap_valid_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;

    logic                   cap_rise, cap_fall, ext_rise, tick, sat;
    logic [BIT_WIDTH:0]     cnt_sum;

    // Synchronize the asynchronous pins and keep one extra stage for edge detect.
    // NOTE: every flop here uses <= so all stages sample the pre-edge values;
    // blocking assignments would collapse the chain into a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_sync_q <= '0;
            ext_sync_q <= '0;
            cap_prev_q <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            cap_sync_q <= {cap_sync_q[SYNC_STAGES-2:0], cap_in};
            ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_clk};
            cap_prev_q <= cap_sync_q[SYNC_STAGES-1];
            ext_prev_q <= ext_sync_q[SYNC_STAGES-1];
        end
    end

    assign cap_rise =  cap_sync_q[SYNC_STAGES-1] & ~cap_prev_q;
    assign cap_fall = ~cap_sync_q[SYNC_STAGES-1] &  cap_prev_q;
    assign ext_rise =  ext_sync_q[SYNC_STAGES-1] & ~ext_prev_q;

    // Free-running prescaler; held at zero while disabled so ticks restart in phase.
    always_ff @(posedge clk) begin
        if (reset || !en) pre_q <= '0;
        else              pre_q <= pre_q + 6'd1;
    end

    // Select the tick source.
    // NOTE: tick gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        tick = 1'b0;
        case (cks)
            2'b00: tick = 1'b1;
            2'b01: tick = (pre_q[2:0] == 3'd7);
            2'b10: tick = (pre_q == 6'd63);
            2'b11: tick = ext_rise;
        endcase
    end

    // One extra bit catches the carry that marks a saturation event.
    assign cnt_sum = {1'b0, cnt_q} + {{BIT_WIDTH{1'b0}}, tick};
    assign sat     = cnt_sum[BIT_WIDTH];

    // Measurement FSM: one counter runs from the start rising edge through the
    // whole period; the falling edge only snapshots it into hi_shadow.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_shadow_d = hi_shadow_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        cap_valid_d = 1'b0;
        ovf_d       = ovf_q & ~ovf_clr;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
                ST_ARM: begin
                    cnt_d = '0;
                    if (cap_rise) state_d = ST_HIGH;
                end
                ST_HIGH: begin
                    if (sat) begin
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ARM;
                    end else if (cap_fall) begin
                        hi_shadow_d = cnt_sum[BIT_WIDTH-1:0];
                        cnt_d       = cnt_sum[BIT_WIDTH-1:0];
                        state_d     = ST_LOW;
                    end else begin
                        cnt_d = cnt_sum[BIT_WIDTH-1:0];
                    end
                end
                ST_LOW: begin
                    if (sat) begin
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ARM;
                    end else if (cap_rise) begin
                        period_d    = cnt_sum[BIT_WIDTH-1:0];
                        high_time_d = hi_shadow_q;
                        cap_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_HIGH;
                    end else begin
                        cnt_d = cnt_sum[BIT_WIDTH-1:0];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d == ST_HIGH) || (state_d == ST_LOW);
    end

    // State and result registers; reset overrides any in-flight measurement.
    // NOTE: every register, including the result holding registers, is reset
    // so software never reads a stale capture after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_shadow_q <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            cap_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_shadow_q <= hi_shadow_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            cap_valid_q <= cap_valid_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign cap_valid = cap_valid_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_timer_pulse_capture.sv
// Directed bench for timer_pulse_capture: reset, /1, /8 and external tick
// measurements, saturation and ovf_clr priority, and disable mid-measurement.
module tb_timer_pulse_capture;

    logic       clk, reset, en, ext_clk, cap_in, ovf_clr;
    logic [1:0] cks;
    logic [7:0] period, high_time;
    logic       cap_valid, ovf, busy;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int cyc       = 0;

    timer_pulse_capture #(.BIT_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cks       (cks),
        .ext_clk   (ext_clk),
        .cap_in    (cap_in),
        .ovf_clr   (ovf_clr),
        .period    (period),
        .high_time (high_time),
        .cap_valid (cap_valid),
        .ovf       (ovf),
        .busy      (busy)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External count clock: period 8 clk, phase kept away from clk edges.
    initial begin
        ext_clk = 1'b0;
        #2;
        forever #40 ext_clk = ~ext_clk;
    end

    // Cycle counter and cap_valid strobe counter.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cap_valid) valid_cnt <= valid_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse train: n periods of 'per' clk with 'hi' clk high; call at posedge+1.
    task automatic gen(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            cap_in = 1'b1;
            repeat (hi) @(posedge clk);
            #1 cap_in = 1'b0;
            repeat (per - hi) @(posedge clk);
            #1;
        end
    endtask

    // Wait up to tmo cycles for n strobes, checking values and spacing.
    task automatic collect(input string tag, input int n, input int tmo,
                           input int per_exp, input int hi_exp, input int spacing);
        int last_t;
        bit got;
        last_t = 0;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (int c = 0; c < tmo && !got; c++) begin
                @(negedge clk);
                if (cap_valid) got = 1'b1;
            end
            if (!got) begin
                check({tag, "_timeout"}, 0, 1);
                break;
            end
            check({tag, "_period"}, 32'(period), per_exp);
            check({tag, "_high"}, 32'(high_time), hi_exp);
            if (spacing > 0 && k > 0) check({tag, "_spacing"}, 32'(cyc - last_t), spacing);
            last_t = cyc;
        end
    endtask

    initial begin
        int v0;
        reset = 1'b1; en = 1'b0; cks = 2'b00; cap_in = 1'b0; ovf_clr = 1'b0;

        // 1: reset with cap_in toggling, then idle with en = 0.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 cap_in = ~cap_in;
        end
        @(negedge clk);
        check("rst_period", 32'(period), 0);
        check("rst_high", 32'(high_time), 0);
        check("rst_valid", 32'(cap_valid), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 cap_in = ~cap_in;
        end
        cap_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("dis_busy", 32'(busy), 0);
        check("dis_no_valid", 32'(valid_cnt), 0);

        // 2: /1, period 20, high 5; four results spaced 20 clk apart.
        @(posedge clk); #1 en = 1'b1;
        repeat (3) @(posedge clk); #1;
        fork
            gen(20, 5, 5);
            collect("div1", 4, 100, 20, 5, 20);
        join
        en = 1'b0;
        repeat (3) @(posedge clk); #1;

        // 3: /8, period 160 clk, high 40 clk. Ticks are exactly 8 clk apart, so
        // any 160/40-cycle window holds exactly 20/5 ticks regardless of phase.
        cks = 2'b01; en = 1'b1;
        repeat (3) @(posedge clk); #1;
        fork
            gen(160, 40, 3);
            collect("div8", 2, 400, 20, 5, 160);
        join
        en = 1'b0;
        repeat (3) @(posedge clk); #1;

        // 4: external ticks every 8 clk, cap period 40 clk, high 16 clk -> 5 / 2.
        cks = 2'b11; en = 1'b1;
        repeat (3) @(posedge clk); #1;
        fork
            gen(40, 16, 3);
            collect("ext", 2, 200, 5, 2, 40);
        join
        en = 1'b0;
        repeat (3) @(posedge clk); #1;

        // 5: saturation at /1. The rise reaches the FSM 3 edges after the pin,
        // then 256 ticks saturate, so ovf appears at the 259th edge.
        cks = 2'b00; en = 1'b1;
        repeat (3) @(posedge clk);
        v0 = valid_cnt;
        @(posedge clk); #1 cap_in = 1'b1;
        repeat (258) @(posedge clk);
        @(negedge clk);
        check("sat_pre_ovf", 32'(ovf), 0);
        check("sat_pre_busy", 32'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        check("sat_ovf", 32'(ovf), 1);
        check("sat_busy", 32'(busy), 0);
        check("sat_period_kept", 32'(period), 5);
        check("sat_high_kept", 32'(high_time), 2);
        check("sat_no_valid", 32'(valid_cnt - v0), 0);
        repeat (40) @(posedge clk); #1 cap_in = 1'b0;
        repeat (5) @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr", 32'(ovf), 0);
        @(posedge clk); #1 cap_in = 1'b1;
        repeat (258) @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_set_wins", 32'(ovf), 1);
        repeat (50) @(posedge clk); #1 cap_in = 1'b0;
        @(negedge clk);
        check("sat_rearm_busy", 32'(busy), 0);

        // 6: disable mid-HIGH for 3 cycles, then a clean 20/5 measurement.
        @(posedge clk); #1 cap_in = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        v0 = valid_cnt;
        @(posedge clk); #1 en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("off_busy", 32'(busy), 0);
        end
        check("off_period", 32'(period), 5);
        check("off_high", 32'(high_time), 2);
        check("off_ovf", 32'(ovf), 1);
        en = 1'b1; cap_in = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rearm_no_partial", 32'(valid_cnt - v0), 0);
        fork
            gen(20, 5, 3);
            collect("rearm", 2, 100, 20, 5, 20);
        join
        check("rearm_count", 32'(valid_cnt - v0), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/timer_pulse_capture.md
Name: timer_pulse_capture

Overview:
- Input-capture companion to the 8-bit compare-match timer channels.
- The timer generates TMO-style waveforms. This block is the receiving end: it measures an incoming pulse train's period (rising to rising) and high time (rising to falling) in prescaled clock ticks.
- It sits beside the timer channels and uses the same clock-select scheme (internal divide or external count clock).
- Typical uses: loopback checking of TMO outputs and measuring external signals.

Parameters:
- BIT_WIDTH, 8, width of the counter and both result registers.
- SYNC_STAGES, 2, number of synchronizer flops on cap_in and ext_clk (minimum 2).

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  measurement enable; 0 forces IDLE.
- cks  in  2  tick source: 00 = clk/1, 01 = clk/8, 10 = clk/64, 11 = rising edge of ext_clk.
- ext_clk  in  1  external count clock (asynchronous, synchronized internally).
- cap_in  in  1  measured signal (asynchronous, synchronized internally).
- ovf_clr  in  1  one-cycle clear for ovf.
- period  out  BIT_WIDTH  last captured period in ticks.
- high_time  out  BIT_WIDTH  last captured high time in ticks.
- cap_valid  out  1  one-cycle strobe when period and high_time update.
- ovf  out  1  sticky flag: measurement abandoned because the counter saturated.
- busy  out  1  high in HIGH or LOW state.

Behaviour:
- Reset: period = 0, high_time = 0, cap_valid = 0, ovf = 0, busy = 0, state = IDLE, counter = 0, prescaler = 0, synchronizer and edge registers = 0.
- Synchronization: cap_in and ext_clk each pass through SYNC_STAGES flops plus one edge-detect register.
  - An edge is seen SYNC_STAGES+1 cycles after the pin changes.
  - Both cap_in edges see the same delay, so measurements are unaffected.
- Tick generation:
  - The prescaler is a free-running 6-bit counter, cleared by reset or by en = 0.
  - /8 ticks when prescaler[2:0] = 7; /64 ticks when prescaler[5:0] = 63; /1 ticks every cycle.
  - cks = 11 ticks on each synchronized ext_clk rising edge.
  - A change of cks takes effect the next cycle. The in-flight result is meaningless but must not hang the FSM.
- Counter arithmetic: next = cnt + tick.
  - If that would exceed 2^BIT_WIDTH - 1, it is a saturation event.
  - At a capture edge, the captured value is cnt + tick (the edge cycle's tick counts), and cnt <= 0 the same cycle.
- FSM states:
  - IDLE: busy = 0. Go to ARM when en = 1.
  - ARM: counter held at 0. On a cap_in rising edge, cnt <= 0 and go to HIGH. Falling edges are ignored.
  - HIGH: count ticks. On a falling edge, latch hi_shadow <= cnt + tick and go to LOW.
  - LOW: count ticks. On a rising edge:
    - period <= cnt_total + tick, where cnt_total counts from the start rising edge and does not restart at the falling edge.
    - high_time <= hi_shadow.
    - cap_valid = 1 for exactly one cycle.
    - Stay back-to-back: cnt_total <= 0 and go to HIGH, so every subsequent rising edge yields a result.
- Counters: a single period counter runs from the rising edge. hi_shadow is a snapshot of that counter, so high_time <= period always.
- Saturation in HIGH or LOW:
  - ovf <= 1 and go to ARM.
  - No cap_valid; period and high_time are unchanged.
- ovf_clr clears ovf. If ovf_clr and a saturation event occur in the same cycle, set wins.
- en = 0 in any state:
  - Next cycle: IDLE, counter and prescaler cleared, busy = 0.
  - period, high_time and ovf are retained.
- Rising and falling edges cannot be flagged in the same cycle. A 1-cycle synchronized high pulse gives consecutive rising then falling detections, producing high_time = 1 at /1.
- reset asserted mid-measurement overrides everything: all reset values are applied next edge, with no cap_valid.
- period, high_time, ovf and busy are registered outputs. cap_valid is registered and asserts in the cycle the new values appear.

Test Plan:
1. Reset with cap_in toggling -> all outputs 0 during reset. After reset with en = 0: busy = 0 and cap_valid never asserts.
2. cks = 00, en = 1, cap_in period 20 clk, high 5 clk, 4 cycles -> cap_valid once per period starting at the second rising edge; period = 20, high_time = 5 every time. Interval between cap_valid strobes is 20 clk.
3. cks = 01, cap_in period 160 clk, high 40 clk -> period = 20, high_time = 5 (±1 tick tolerance for prescaler phase).
4. cks = 11, ext_clk period 8 clk, cap_in period 40 clk, high 16 clk -> period = 5, high_time = 2 (±1).
5. cks = 00, cap_in held high 300 clk after a rising edge -> ovf = 1 when the counter would pass 255. State returns to ARM, no cap_valid, old period/high_time kept. Then ovf_clr pulse -> ovf = 0. ovf_clr coincident with a new saturation -> ovf stays 1.
6. en dropped for 3 cycles mid-HIGH, then reasserted with the 20/5 stimulus -> busy = 0 while disabled and stale outputs retained. The first result after re-arm is period = 20, high_time = 5, with no partial result emitted.
